// File: rtl/ahb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bram_ctrl
// Purpose  : AHB-Lite slave in front of a dual-port block RAM. Port A is the
//            byte-enabled write port and port B is a registered (1-cycle)
//            read port. Reads and writes complete with zero wait states.
//            Because port B is read-first, a read directly after a write to
//            the same word would return stale data; the last committed write
//            is therefore held and forwarded byte-by-byte into HRDATA.
// Ports    : HCLK/HRESET                 clock, synchronous active-high reset
//            HSEL/HADDR/HTRANS/HSIZE/
//            HWRITE/HREADY/HWDATA        AHB-Lite slave inputs
//            HREADYOUT/HRESP/HRDATA      AHB-Lite slave outputs
//            BRAM_ADDRA/WDATA/WE         BRAM write port A
//            BRAM_ADDRB/BRAM_RDATA       BRAM read port B (registered data)
// Options  : `define AHB_BRAM_ALIGN_CHECK_EN to reject misaligned transfers
//            with a two-cycle AHB ERROR response. Without it HRESP is 0 and
//            low address bits only select byte lanes.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
    input  logic [31:0]           BRAM_RDATA
);

    // Data-phase registers
    logic                  r_dph_valid;
    logic                  r_dph_write;
    logic [ADDR_WIDTH-1:0] r_dph_addr;
    logic [3:0]            r_dph_be;

    // Last committed write, used to patch the stale BRAM read
    logic                  r_fwd_valid;
    logic [ADDR_WIDTH-1:0] r_fwd_addr;
    logic [31:0]           r_fwd_data;
    logic [3:0]            r_fwd_be;

    logic [3:0]            w_be;
    logic                  w_accept_ok;
    logic                  w_commit;
    logic                  w_fwd_hit;

    // Upper address bits alias; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here
    logic                  w_unused_ok;
    assign w_unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    always_comb begin
        w_be = 4'b1111;
        if (HSIZE == 3'd0) begin
            w_be = 4'b0001 << HADDR[1:0];
        end else if (HSIZE == 3'd1) begin
            w_be = HADDR[1] ? 4'b1100 : 4'b0011;
        end
    end

`ifdef AHB_BRAM_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_OK   = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;
    logic   w_misaligned;

    assign w_misaligned = ((HSIZE == 3'd1) && HADDR[0])
                       || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                       || (HSIZE > 3'd2);
    // During ERR1 the bus is stalled by us, so nothing may be captured
    assign w_accept     = HSEL && HTRANS[1] && HREADY && (r_state != ST_ERR1);
    assign w_accept_ok  = w_accept && !w_misaligned;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= ST_OK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        case (r_state)
            ST_OK: begin
                if (w_accept && w_misaligned) w_state_nxt = ST_ERR1;
            end
            ST_ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP       = 1'b1;
                // A transfer presented here is a normal address phase
                w_state_nxt = (w_accept && w_misaligned) ? ST_ERR1 : ST_OK;
            end
            default: w_state_nxt = ST_OK;
        endcase
    end
`else
    assign w_accept_ok = HSEL && HTRANS[1] && HREADY;
    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
`endif

    // Write port: the commit happens at the edge ending the data phase.
    // Reset kills a write that is in flight.
    assign w_commit   = r_dph_valid && r_dph_write && !HRESET;
    assign BRAM_ADDRA = r_dph_addr;
    assign BRAM_WDATA = HWDATA;
    assign BRAM_WE    = w_commit ? r_dph_be : 4'b0000;

    // Read port is addressed straight from the address phase so the data
    // arrives in the data phase without a wait state.
    assign BRAM_ADDRB = HADDR[ADDR_WIDTH+1:2];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dph_valid <= 1'b0;
            r_dph_write <= 1'b0;
            r_dph_addr  <= '0;
            r_dph_be    <= 4'b0000;
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= 32'h0;
            r_fwd_be    <= 4'b0000;
        end else begin
            r_dph_valid <= w_accept_ok;
            if (w_accept_ok) begin
                r_dph_write <= HWRITE;
                r_dph_addr  <= HADDR[ADDR_WIDTH+1:2];
                r_dph_be    <= w_be;
            end
            if (w_commit) begin
                r_fwd_valid <= 1'b1;
                r_fwd_addr  <= r_dph_addr;
                r_fwd_data  <= HWDATA;
                r_fwd_be    <= r_dph_be;
            end else begin
                r_fwd_valid <= 1'b0;
            end
        end
    end

    assign w_fwd_hit = r_fwd_valid && (r_fwd_addr == r_dph_addr);

    // Merge forwarded bytes over the (stale) BRAM word
    always_comb begin
        HRDATA = 32'h0;
        if (r_dph_valid && !r_dph_write) begin
            for (int b = 0; b < 4; b++) begin
                HRDATA[8*b +: 8] = (w_fwd_hit && r_fwd_be[b]) ? r_fwd_data[8*b +: 8]
                                                                : BRAM_RDATA[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_bram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_bram_ctrl
// Purpose  : Directed self-checking bench for ahb_bram_ctrl with a read-first
//            block RAM model on ports A/B.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_bram_ctrl;

    localparam int ADDR_WIDTH = 12;

    logic                  HCLK = 1'b0;
    logic                  HRESET;
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic                  HWRITE;
    logic                  HREADY;
    logic [31:0]           HWDATA;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    logic [ADDR_WIDTH-1:0] BRAM_ADDRA;
    logic [31:0]           BRAM_WDATA;
    logic [3:0]            BRAM_WE;
    logic [ADDR_WIDTH-1:0] BRAM_ADDRB;
    logic [31:0]           BRAM_RDATA;

    logic                  hready_block;
    logic                  mem_clr;
    logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Single-slave system: bus HREADY follows our HREADYOUT unless blocked
    assign HREADY = hready_block ? 1'b0 : HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_bram_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HREADY     (HREADY),
        .HWDATA     (HWDATA),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .BRAM_ADDRA (BRAM_ADDRA),
        .BRAM_WDATA (BRAM_WDATA),
        .BRAM_WE    (BRAM_WE),
        .BRAM_ADDRB (BRAM_ADDRB),
        .BRAM_RDATA (BRAM_RDATA)
    );

    // Read-first dual-port RAM with registered read data
    always @(posedge HCLK) begin
        if (mem_clr) begin
            for (int i = 0; i < (1<<ADDR_WIDTH); i++) mem[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (BRAM_WE[b]) mem[BRAM_ADDRA][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
        end
        BRAM_RDATA <= mem[BRAM_ADDRB];
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HSIZE  = 3'd2;
        HADDR  = 32'h0;
    endtask

    task automatic drive_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; hready_block = 1'b0; mem_clr = 1'b1; HWDATA = 32'h0;
        drive_idle();
        tick(); tick();
        mem_clr = 1'b0;
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b expected 0", HRESP); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata: got %h expected 00000000", HRDATA); end
        n_checks++; if (BRAM_WE !== 4'b0000) begin n_fail++; $display("FAIL reset_we: got %b expected 0000", BRAM_WE); end
        HRESET = 1'b0;
        tick();
    endtask

    task automatic test_word_forward();
        drive_xfer(1'b1, 32'h010, 3'd2);
        tick();
        HWDATA = 32'h12345678;
        drive_xfer(1'b0, 32'h010, 3'd2);
        #1;
        n_checks++; if (BRAM_WE !== 4'b1111) begin n_fail++; $display("FAIL word_we: got %b expected 1111", BRAM_WE); end
        n_checks++; if (BRAM_ADDRA !== 12'd4) begin n_fail++; $display("FAIL word_addra: got %0d expected 4", BRAM_ADDRA); end
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL word_wr_ready: got %b expected 1", HREADYOUT); end
        tick();
        drive_idle(); HWDATA = 32'h0;
        #1;
        n_checks++; if (HRDATA !== 32'h12345678) begin n_fail++; $display("FAIL word_fwd_read: got %h expected 12345678", HRDATA); end
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL word_rd_ready: got %b expected 1", HREADYOUT); end
        tick();
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL word_idle_hrdata: got %h expected 00000000", HRDATA); end
    endtask

    task automatic test_byte_write();
        drive_xfer(1'b1, 32'h011, 3'd0);
        tick();
        HWDATA = 32'h0000AB00;
        drive_idle();
        #1;
        n_checks++; if (BRAM_WE !== 4'b0010) begin n_fail++; $display("FAIL byte_we: got %b expected 0010", BRAM_WE); end
        tick();
        HWDATA = 32'h0;
        tick();
        // Upper address bits alias onto the same word
        drive_xfer(1'b0, 32'h0001_4010, 3'd2);
        #1;
        n_checks++; if (BRAM_ADDRB !== 12'd4) begin n_fail++; $display("FAIL byte_alias_addrb: got %0d expected 4", BRAM_ADDRB); end
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 32'h1234AB78) begin n_fail++; $display("FAIL byte_bram_read: got %h expected 1234ab78", HRDATA); end
        tick();
    endtask

    task automatic test_back_to_back();
        // Partial forward: byte 2 from the write, rest from the RAM
        drive_xfer(1'b1, 32'h012, 3'd0);
        tick();
        HWDATA = 32'h00CD0000;
        drive_xfer(1'b0, 32'h010, 3'd2);
        #1;
        n_checks++; if (BRAM_WE !== 4'b0100) begin n_fail++; $display("FAIL b2b_we: got %b expected 0100", BRAM_WE); end
        tick();
        drive_idle(); HWDATA = 32'h0;
        #1;
        n_checks++; if (HRDATA !== 32'h12CDAB78) begin n_fail++; $display("FAIL b2b_merge_read: got %h expected 12cdab78", HRDATA); end
        tick();
    endtask

    task automatic test_no_transfer();
        hready_block = 1'b1;
        drive_xfer(1'b1, 32'h030, 3'd2);
        tick();
        hready_block = 1'b0;
        drive_idle(); HWDATA = 32'hDEADBEEF;
        #1;
        n_checks++; if (BRAM_WE !== 4'b0000) begin n_fail++; $display("FAIL noxfer_hready_we: got %b expected 0000", BRAM_WE); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL noxfer_hrdata: got %h expected 00000000", HRDATA); end
        // BUSY is not a transfer either
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h030;
        tick();
        drive_idle();
        #1;
        n_checks++; if (BRAM_WE !== 4'b0000) begin n_fail++; $display("FAIL noxfer_busy_we: got %b expected 0000", BRAM_WE); end
        tick(); tick();
        HWDATA = 32'h0;
        n_checks++; if (mem[12] !== 32'h0) begin n_fail++; $display("FAIL noxfer_mem: got %h expected 00000000", mem[12]); end
    endtask

    task automatic test_reset_during_write();
        drive_xfer(1'b1, 32'h020, 3'd2);
        tick();
        HWDATA = 32'h0BADF00D;
        drive_idle();
        tick(); tick();
        drive_xfer(1'b1, 32'h020, 3'd2);
        tick();
        HWDATA = 32'hFFFFFFFF; HRESET = 1'b1;
        drive_idle();
        #1;
        n_checks++; if (BRAM_WE !== 4'b0000) begin n_fail++; $display("FAIL rstwr_we: got %b expected 0000", BRAM_WE); end
        tick();
        n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rstwr_ready: got %b expected 1", HREADYOUT); end
        n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL rstwr_hresp: got %b expected 0", HRESP); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL rstwr_hrdata: got %h expected 00000000", HRDATA); end
        HRESET = 1'b0; HWDATA = 32'h0;
        tick();
        n_checks++; if (mem[8] !== 32'h0BADF00D) begin n_fail++; $display("FAIL rstwr_mem: got %h expected 0badf00d", mem[8]); end
        drive_xfer(1'b0, 32'h020, 3'd2);
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 32'h0BADF00D) begin n_fail++; $display("FAIL rstwr_readback: got %h expected 0badf00d", HRDATA); end
        tick();
    endtask

    task automatic test_align();
        drive_xfer(1'b1, 32'h013, 3'd1);
        tick();
        HWDATA = 32'hBEEF0000;
        drive_idle();
`ifdef AHB_BRAM_ALIGN_CHECK_EN
        #1;
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_fail++; $display("FAIL align_err1: got rdy/resp %b expected 01", {HREADYOUT, HRESP}); end
        n_checks++; if (BRAM_WE !== 4'b0000) begin n_fail++; $display("FAIL align_err1_we: got %b expected 0000", BRAM_WE); end
        tick();
        HWDATA = 32'h0;
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_fail++; $display("FAIL align_err2: got rdy/resp %b expected 11", {HREADYOUT, HRESP}); end
        n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL align_hrdata: got %h expected 00000000", HRDATA); end
        // New transfer accepted during the second error cycle
        drive_xfer(1'b0, 32'h010, 3'd2);
        tick();
        drive_idle();
        #1;
        n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL align_okay: got rdy/resp %b expected 10", {HREADYOUT, HRESP}); end
        n_checks++; if (HRDATA !== 32'h12CDAB78) begin n_fail++; $display("FAIL align_read_err2: got %h expected 12cdab78", HRDATA); end
        n_checks++; if (mem[4] !== 32'h12CDAB78) begin n_fail++; $display("FAIL align_mem: got %h expected 12cdab78", mem[4]); end
        tick();
`else
        #1;
        n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL noalign_hresp: got %b expected 0", HRESP); end
        n_checks++; if (BRAM_WE !== 4'b1100) begin n_fail++; $display("FAIL noalign_we: got %b expected 1100", BRAM_WE); end
        tick();
        HWDATA = 32'h0;
        tick();
        n_checks++; if (mem[4] !== 32'hBEEFAB78) begin n_fail++; $display("FAIL noalign_mem: got %h expected beefab78", mem[4]); end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] sb [16];
        drive_xfer(1'b1, 32'h000, 3'd2);
        for (int i = 0; i < 16; i++) begin
            tick();
            sb[i]  = {8'hA5, 8'(i), 8'(8'hFF - i), 8'h3C};
            HWDATA = sb[i];
            drive_xfer(1'b0, 32'(i * 4), 3'd2);
            tick();
            HWDATA = 32'h0;
            if (i < 15) drive_xfer(1'b1, 32'((i + 1) * 4), 3'd2);
            else        drive_idle();
            #1;
            n_checks++; if (HRDATA !== sb[i] || HREADYOUT !== 1'b1) begin
                n_fail++; $display("FAIL stream_fwd[%0d]: got %h rdy %b expected %h rdy 1", i, HRDATA, HREADYOUT, sb[i]);
            end
        end
        tick();
        drive_xfer(1'b0, 32'h000, 3'd2);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i < 15) drive_xfer(1'b0, 32'((i + 1) * 4), 3'd2);
            else        drive_idle();
            #1;
            n_checks++; if (HRDATA !== sb[i] || HREADYOUT !== 1'b1) begin
                n_fail++; $display("FAIL stream_bram[%0d]: got %h rdy %b expected %h rdy 1", i, HRDATA, HREADYOUT, sb[i]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_word_forward();
        test_byte_write();
        test_back_to_back();
        test_no_transfer();
        test_reset_during_write();
        test_align();
        test_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
